// File: rtl/pattern_detector_pkg.sv
// Shared types and helpers for the serial pattern detector.
package pattern_detector_pkg;

  // Detector FSM state; the encoding is visible on the state output port.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01
  } state_t;

  // Largest pattern length any instance may be configured for.
  localparam int MAX_LEN_LIMIT = 16;

  // A pattern length is usable only when it is non-zero and fits the history.
  function automatic logic len_ok(input logic [31:0] len, input int max_len);
    logic ok;
    ok = (len != 32'd0) && (len <= 32'(max_len));
    return ok;
  endfunction

endpackage

// File: rtl/pattern_detector_history.sv
// History shift register plus count of usable (valid) history bits.
module pd_history
  import pattern_detector_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int FW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               flush,    // forget all history (pattern reload)
  input  logic               shift,    // accept x as the newest bit
  input  logic               x,
  input  logic               restart,  // non-overlapping match: matched bits become unusable
  output logic [MAX_LEN-1:0] hist,
  output logic [FW-1:0]      fill
);

  localparam logic [FW-1:0] FILL_MAX = FW'(MAX_LEN);

  logic [FW-1:0] fill_next;

  // Next fill value for an accepted bit: restart on a consumed match, else saturating increment.
  always_comb begin
    fill_next = fill;
    if (restart) begin
      fill_next = {FW{1'b0}};
    end else if (fill == FILL_MAX) begin
      fill_next = FILL_MAX;
    end else begin
      fill_next = fill + {{(FW-1){1'b0}}, 1'b1};
    end
  end

  // History and fill registers; hist[0] always holds the newest accepted bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hist <= {MAX_LEN{1'b0}};
      fill <= {FW{1'b0}};
    end else if (flush) begin
      hist <= {MAX_LEN{1'b0}};
      fill <= {FW{1'b0}};
    end else if (shift) begin
      hist <= {hist[MAX_LEN-2:0], x};
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector: programmable pattern/length, overlapping or
// non-overlapping detection, registered match pulse and saturating counter.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         x,
  input  logic                         x_valid,
  input  logic                         load,
  input  logic [MAX_LEN-1:0]           pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
  input  logic                         overlap,
  output logic                         y,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(MAX_LEN+1)-1:0] fill,
  output logic [1:0]                   state
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t             state_q;
  state_t             state_d;
  logic [MAX_LEN-1:0] pat_r;
  logic [LW-1:0]      len_r;
  logic               ovl_r;
  logic [MAX_LEN-1:0] hist;
  logic               len_valid;
  logic               accept;
  logic [MAX_LEN:0]   window;
  logic [MAX_LEN:0]   mask;
  logic               bits_eq;
  logic               fill_ok;
  logic               match;

  assign state     = state_q;
  assign len_valid = len_ok(32'(pat_len), MAX_LEN);

  // A bit is taken only while armed, when valid, and when no reload competes for the edge.
  assign accept = (state_q == ARMED) && x_valid && !load;

  // Compare the newest len_r bits of {hist, x}; pattern MSB (oldest) lines up with window[len_r-1].
  always_comb begin
    window  = {hist, x};
    mask    = ({{MAX_LEN{1'b0}}, 1'b1} << len_r) - {{MAX_LEN{1'b0}}, 1'b1};
    bits_eq = ((window ^ {1'b0, pat_r}) & mask) == {(MAX_LEN+1){1'b0}};
    fill_ok = ({1'b0, fill} + {{LW{1'b0}}, 1'b1}) >= {1'b0, len_r};
    match   = accept && bits_eq && fill_ok;
  end

  // Next-state logic: every load decides the state, anything else holds it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load && len_valid) begin
          state_d = ARMED;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (load && !len_valid) begin
          state_d = IDLE;
        end else begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow copies of the configuration; an invalid load leaves them untouched.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pat_r <= {MAX_LEN{1'b0}};
      len_r <= {LW{1'b0}};
      ovl_r <= 1'b0;
    end else if (load && len_valid) begin
      pat_r <= pattern;
      len_r <= pat_len;
      ovl_r <= overlap;
    end
  end

  // Match pulse and saturating match counter; a load restarts both.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      y           <= 1'b0;
      match_count <= {CNT_W{1'b0}};
    end else if (load) begin
      y           <= 1'b0;
      match_count <= {CNT_W{1'b0}};
    end else begin
      y <= match;
      if (match && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  pd_history #(
    .MAX_LEN (MAX_LEN),
    .FW      (LW)
  ) u_history (
    .clk     (clk),
    .clr     (clr),
    .flush   (load),
    .shift   (accept),
    .x       (x),
    .restart (match && !ovl_r),
    .hist    (hist),
    .fill    (fill)
  );

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port x, input, 1, serial data bit.
REQ-006 SHALL have port x_valid, input, 1, x is sampled only when high.
REQ-007 SHALL have port load, input, 1, capture pattern/pat_len/overlap on this edge.
REQ-008 SHALL have port pattern, input, MAX_LEN, target bits; pattern[pat_len-1] is the first bit received and pattern[0] the last.
REQ-009 SHALL have port pat_len, input, $clog2(MAX_LEN+1), pattern length.
REQ-010 SHALL have port overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port y, output, 1, registered one-cycle match pulse.
REQ-012 SHALL have port match_count, output, CNT_W, saturating count of matches.
REQ-013 SHALL have port fill, output, $clog2(MAX_LEN+1), number of valid history bits held.
REQ-014 SHALL have port state, output, 2, FSM state (IDLE=2'b00, ARMED=2'b01).

Function
REQ-015 SHALL hold shadow registers pat_r, len_r and ovl_r, written only on a clock edge with load=1.
REQ-016 SHALL treat a load with pat_len=0 or pat_len>MAX_LEN as invalid: go to IDLE, leave the shadow registers unchanged.
REQ-017 SHALL go IDLE->ARMED on a valid load; ARMED->ARMED on a valid load; and ARMED->IDLE on an invalid load.
REQ-018 SHALL, on any load edge: clear the history and fill, clear match_count, drive y<=0, and ignore x that cycle.
REQ-019 SHALL give load priority over x_valid when both are asserted.
REQ-020 SHALL, in ARMED with x_valid=1 and load=0, shift x into history: hist <= {hist[MAX_LEN-2:0], x}, with hist[0] as the newest bit.
REQ-021 SHALL evaluate the match combinationally on the window {hist, x}: the last len_r bits equal pat_r[len_r-1:0] and fill >= len_r-1.
REQ-022 SHALL register y <= match on that same edge, so y is high for exactly the cycle following the edge that sampled the completing bit.
REQ-023 SHALL drive y <= 0 on every edge where x_valid=0 or the state is IDLE; history, fill and the count SHALL hold on those edges.
REQ-024 SHALL increment fill by 1 per accepted bit, saturating at MAX_LEN.
REQ-025 SHALL, on a match with ovl_r=0, set fill <= 0 so that no bit of a matched window contributes to a later match.
REQ-026 SHALL, on a match with ovl_r=1, increment fill normally so that matches may share bits.
REQ-027 SHALL increment match_count by 1 per match and saturate at all-ones (no wrap).
REQ-028 SHALL, for len_r=1, match on every accepted bit equal to pat_r[0].

Reset
REQ-029 SHALL, with clr=1, asynchronously force: state=IDLE, y=0, match_count=0, fill=0, hist=0, pat_r=0, len_r=0, ovl_r=0.
REQ-030 SHALL, when clr is asserted mid-stream, discard partial matches; detection resumes only after a new valid load.

Structure
REQ-031 SHALL put the state enum (IDLE, ARMED) and its 2-bit encoding in the shared package pattern_detector_pkg.
REQ-032 SHALL place the history shift register and fill counter in one sub-module, pd_history; the FSM, compare logic and counter stay in the top module.
REQ-033 SHALL contain no latches; every output SHALL be a flop.

Verification
REQ-034 SHALL cover: load pattern=8'h0D, len=4, overlap=1; stream 1,1,0,1,1,0,1 -> y pulses after bits 4 and 7; match_count=2.
REQ-035 SHALL cover: the same stream with overlap=0 -> a single y pulse after bit 4; match_count=1; fill=3 at the end.
REQ-036 SHALL cover: len=1, pattern bit0=1, stream 1,1,1 -> y high for three consecutive cycles; match_count=3.
REQ-037 SHALL cover: the 1101 stream with x_valid=0 gaps inserted between every bit -> same match count as without gaps; y is never high in a gap cycle.
REQ-038 SHALL cover: CNT_W=2 with 5 matches -> match_count sticks at 2'b11; and clr pulsed after bits 1,1,0 -> all outputs 0 and state=IDLE with no later y until reload.
REQ-039 SHALL cover: load with pat_len=0 while ARMED -> state=IDLE, y stays 0; then load and x_valid high together -> load wins and that x is ignored.
